// File: rtl/div_issue_ctrl.sv
// Issue/complete controller for div.w/mod.w/div.wu/mod.wu in front of an iterative divider.
// Resolves divide-by-zero, signed overflow and repeated operands locally; survives flush.
module div_issue_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TAG_W    = 5,
  parameter bit          REUSE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,

  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        in_op_i,
  input  logic [DATA_W-1:0] in_a_i,
  input  logic [DATA_W-1:0] in_b_i,
  input  logic [TAG_W-1:0]  in_rd_i,

  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [TAG_W-1:0]  out_rd_o,
  output logic              out_div_zero_o,

  output logic              dv_valid_in_o,
  output logic [DATA_W-1:0] dv_a_o,
  output logic [DATA_W-1:0] dv_b_o,
  output logic              dv_sign_o,
  input  logic [DATA_W-1:0] dv_quot_i,
  input  logic [DATA_W-1:0] dv_rem_i,
  input  logic              dv_valid_out_i
);

  localparam logic [DATA_W-1:0] MinVal  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] AllOnes = {DATA_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StWait, StResp, StDrain} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] a_q, b_q;
  logic              sign_q;
  logic              rem_sel_q;
  logic [TAG_W-1:0]  rd_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_div_zero_q;
  logic              dv_start_q;

  logic              cache_valid_q;
  logic [DATA_W-1:0] cache_a_q, cache_b_q, cache_quot_q, cache_rem_q;
  logic              cache_sign_q;

  logic              accept;
  logic              in_sign;
  logic              is_zero, is_ovf, is_hit, run_div;
  logic [DATA_W-1:0] fast_res;
  logic              wait_done;

  // Classification of the offered op, in priority order zero > overflow > cache hit.
  always_comb begin
    in_sign = ~in_op_i[1];
    accept  = in_valid_i & in_ready_o;
    is_zero = (in_b_i == '0);
    is_ovf  = ~is_zero & in_sign & (in_a_i == MinVal) & (in_b_i == AllOnes);
    is_hit  = ~is_zero & ~is_ovf & REUSE_EN & cache_valid_q & (in_a_i == cache_a_q) &
              (in_b_i == cache_b_q) & (in_sign == cache_sign_q);
    run_div = ~is_zero & ~is_ovf & ~is_hit;
    fast_res = '0;
    if (is_zero) begin
      fast_res = in_op_i[0] ? in_a_i : AllOnes;
    end else if (is_ovf) begin
      fast_res = in_op_i[0] ? '0 : MinVal;
    end else if (is_hit) begin
      fast_res = in_op_i[0] ? cache_rem_q : cache_quot_q;
    end
    wait_done = (state_q == StWait) & dv_valid_out_i & ~flush_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = run_div ? StWait : StResp;
        end
      end
      StWait: begin
        if (dv_valid_out_i) begin
          state_d = flush_i ? StIdle : StResp;
        end else if (flush_i) begin
          state_d = StDrain;
        end
      end
      StResp: begin
        if (out_ready_i || flush_i) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (dv_valid_out_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready_o     = (state_q == StIdle) & ~flush_i;
    out_valid_o    = (state_q == StResp);
    out_data_o     = out_data_q;
    out_rd_o       = rd_q;
    out_div_zero_o = out_div_zero_q;
    dv_valid_in_o  = dv_start_q;
    dv_a_o         = a_q;
    dv_b_o         = b_q;
    dv_sign_o      = sign_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q            <= '0;
      b_q            <= '0;
      sign_q         <= 1'b0;
      rem_sel_q      <= 1'b0;
      rd_q           <= '0;
      out_data_q     <= '0;
      out_div_zero_q <= 1'b0;
      dv_start_q     <= 1'b0;
      cache_valid_q  <= 1'b0;
      cache_a_q      <= '0;
      cache_b_q      <= '0;
      cache_sign_q   <= 1'b0;
      cache_quot_q   <= '0;
      cache_rem_q    <= '0;
    end else begin
      dv_start_q <= accept & run_div;
      if (accept) begin
        a_q            <= in_a_i;
        b_q            <= in_b_i;
        sign_q         <= in_sign;
        rem_sel_q      <= in_op_i[0];
        rd_q           <= in_rd_i;
        out_div_zero_q <= is_zero;
        if (!run_div) begin
          out_data_q <= fast_res;
        end
      end
      // Flushed or drained results never reach the output or the cache.
      if (wait_done) begin
        out_data_q    <= rem_sel_q ? dv_rem_i : dv_quot_i;
        cache_valid_q <= 1'b1;
        cache_a_q     <= a_q;
        cache_b_q     <= b_q;
        cache_sign_q  <= sign_q;
        cache_quot_q  <= dv_quot_i;
        cache_rem_q   <= dv_rem_i;
      end
    end
  end

endmodule
